// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one single-port synchronous SRAM between N_PORTS
// requesters using round-robin arbitration with bounded burst locking.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   req/write           - per-port request and write (1) / read (0)
//   addr/wdata/wmask    - per-port packed address, write data, byte mask
//   gnt                 - combinational one-hot grant
//   rvalid/rdata        - registered per-port read valid, broadcast data
//   sram_addr/wdata/wen - SRAM command side; sram_rdata - SRAM read data
module sram_arbiter #(
    parameter int N_PORTS    = 3,
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 11,
    parameter int MAX_BURST  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_PORTS-1:0]            req,
    input  logic [N_PORTS-1:0]            write,
    input  logic [N_PORTS*ADDR_WIDTH-1:0] addr,
    input  logic [N_PORTS*WIDTH-1:0]      wdata,
    input  logic [N_PORTS*WIDTH/8-1:0]    wmask,
    output logic [N_PORTS-1:0]            gnt,
    output logic [N_PORTS-1:0]            rvalid,
    output logic [WIDTH-1:0]              rdata,
    output logic [ADDR_WIDTH-1:0]         sram_addr,
    output logic [WIDTH-1:0]              sram_wdata,
    output logic [WIDTH/8-1:0]            sram_wen,
    input  logic [WIDTH-1:0]              sram_rdata
);

    localparam int IW = $clog2(N_PORTS);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam int BW = WIDTH / 8;

    logic          owner_vld;
    logic [IW-1:0] owner;
    logic [CW-1:0] burst_cnt;
    logic [IW-1:0] ptr;

    logic          keep;
    logic          sel_vld;
    logic [IW-1:0] sel_idx;
    logic [IW-1:0] gnt_idx;
    logic          any_gnt;
    logic          owner_req;

    // Owner's current request; loop avoids indexing past N_PORTS.
    always_comb begin
        owner_req = 1'b0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (owner == IW'(i)) owner_req = req[i];
        end
    end

    // First requester at or after ptr, wrapping modulo N_PORTS.
    always_comb begin
        int j;
        sel_vld = 1'b0;
        sel_idx = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            j = int'(ptr) + i;
            if (j >= N_PORTS) j = j - N_PORTS;
            if (!sel_vld && req[j]) begin
                sel_vld = 1'b1;
                sel_idx = IW'(j);
            end
        end
    end

    assign keep    = owner_vld && owner_req && (burst_cnt < CW'(MAX_BURST));
    assign gnt_idx = keep ? owner : sel_idx;
    assign any_gnt = !rst && (keep || sel_vld);

    always_comb begin
        gnt = '0;
        if (any_gnt) gnt[gnt_idx] = 1'b1;
    end

    // Command mux; idle cycles present port 0 fields with writes disabled.
    always_comb begin
        sram_addr  = addr[ADDR_WIDTH-1:0];
        sram_wdata = wdata[WIDTH-1:0];
        sram_wen   = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            if (gnt[k]) begin
                sram_addr  = addr[k*ADDR_WIDTH +: ADDR_WIDTH];
                sram_wdata = wdata[k*WIDTH +: WIDTH];
                sram_wen   = write[k] ? wmask[k*BW +: BW] : '0;
            end
        end
    end

    assign rdata = sram_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_vld <= 1'b0;
            owner     <= '0;
            burst_cnt <= '0;
            ptr       <= '0;
            rvalid    <= '0;
        end else begin
            rvalid <= gnt & ~write;
            if (any_gnt) begin
                owner_vld <= 1'b1;
                owner     <= gnt_idx;
                burst_cnt <= keep ? burst_cnt + 1'b1 : CW'(1);
                ptr       <= (gnt_idx == IW'(N_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
            end else begin
                owner_vld <= 1'b0;
                burst_cnt <= '0;
            end
        end
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares one single-port synchronous SRAM (sram_sync-style: one access per cycle, write-enable per byte, read data one cycle after address) between N_PORTS requesters. Each cycle the block grants at most one requester, routes its address, write data and byte mask to the SRAM, and returns read data with a per-port valid one cycle later. Round-robin arbitration with bounded burst locking gives fair, starvation-free access. It sits between on-chip masters (e.g. display fetch, DMA, bus bridge) and a shared framebuffer or scratch RAM.

## Interface
- N_PORTS, 3: number of requesters, 2..8
- WIDTH, 32: data width, multiple of 8
- ADDR_WIDTH, 11: SRAM word-address width
- MAX_BURST, 2: max consecutive grants one port keeps while others wait, >= 1

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous reset, active high
- req  in  N_PORTS  access request per port
- write  in  N_PORTS  1 = write, 0 = read, per port
- addr  in  N_PORTS*ADDR_WIDTH  word address, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
- wdata  in  N_PORTS*WIDTH  write data, port k at [k*WIDTH +: WIDTH]
- wmask  in  N_PORTS*WIDTH/8  byte write mask per port
- gnt  out  N_PORTS  one-hot grant, combinational, same cycle as req
- rvalid  out  N_PORTS  registered; read data valid for port k
- rdata  out  WIDTH  read data, broadcast to all ports; = sram_rdata
- sram_addr  out  ADDR_WIDTH  to SRAM addr
- sram_wdata  out  WIDTH  to SRAM wdata
- sram_wen  out  WIDTH/8  to SRAM byte wen
- sram_rdata  in  WIDTH  from SRAM rdata

## Operation
- State: owner_vld, owner (index), burst_cnt (0..MAX_BURST), ptr (round-robin start index).
- Arbitration per cycle (rst low):
  - If owner_vld, req[owner], burst_cnt < MAX_BURST: grant owner; burst_cnt++.
  - Else: grant first set req[] searching ptr, ptr+1, ... mod N_PORTS; owner = that port, owner_vld = 1, burst_cnt = 1.
  - No req: gnt = 0, owner_vld = 0, burst_cnt = 0; ptr unchanged.
  - On every grant to port k: ptr = (k+1) mod N_PORTS.
- A request is accepted exactly in a cycle where req[k] && gnt[k]; requester holds addr/write/wdata/wmask stable until then.
- Granted port k: sram_addr = addr[k]; sram_wdata = wdata[k]; sram_wen = write[k] ? wmask[k] : 0.
- No grant: sram_wen = 0; sram_addr/sram_wdata = port 0 fields (don't-care, must not write).
- Granted read (write[k] = 0): rvalid[k] = 1 next cycle only, all other rvalid bits 0. Writes never raise rvalid.
- wmask = 0 on a write: consumes the slot, no SRAM change, no rvalid.
- MAX_BURST = 1: pure round-robin. A lone requester is granted every cycle regardless of MAX_BURST (burst limit only applies when re-arbitration finds no other requester → same port regranted, burst_cnt = 1).

## Timing
- Reset values: gnt = 0, rvalid = 0, sram_wen = 0, owner_vld = 0, burst_cnt = 0, ptr = 0.
- While rst high: gnt = 0, sram_wen = 0 (combinationally forced); no SRAM writes.
- Grant latency 0 cycles; read data latency 1 cycle (rvalid and rdata in cycle after grant). Throughput 1 access/cycle.
- Read granted in cycle t with rst rising in t+1: rvalid still asserted in t+1 (register loaded at end of t), cleared at end of t+1.
- Read-after-write same address in consecutive cycles returns new data (SRAM write completes at grant-cycle edge).
- Worst-case wait for a requesting port: (N_PORTS-1)*MAX_BURST cycles.

## Test plan
- Reset: hold rst 3 cycles with all req = 1 -> gnt = 0, sram_wen = 0, rvalid = 0 throughout; first grant after release goes to port 0.
- Write/read: port 1 writes addr 5 = 0xDEADBEEF, wmask 0xF, then reads addr 5 -> gnt[1] both cycles, rvalid = 3'b010 one cycle after read, rdata = 0xDEADBEEF.
- Fairness: N_PORTS = 3, MAX_BURST = 2, all req held high -> grant sequence 0,0,1,1,2,2,0,0,... for 12 cycles.
- Byte mask: write 0x11223344 mask 0xF, then 0xAAAAAAAA mask 0x2 to same address, read -> 0x1122AA44.
- Early release: port 0 req for 1 cycle while ports 1,2 wait -> next grant port 1, ptr = 2; wmask = 0 write leaves memory unchanged.
- Reset mid-operation: read granted cycle t, rst high cycles t+1..t+2 -> rvalid high in t+1 only, no SRAM write during reset, arbitration restarts at port 0.
